ble4_lut4_cfg: RTL and testbench
================================

Name: ble4_lut4_cfg

Overview:
- LUT4 stage of the BLE that drives the flip-flop's ff_D input; its output is registered downstream into ff_Q.
- Holds its own 16-bit truth table and 1 registered/combinational mode bit.
- Loads new configuration bits serially over a valid/ready handshake into a shadow register, then commits them atomically to the active configuration.
- Also provides a serial tail output so that several BLEs can be daisy-chained during configuration.

Parameters:
- LUT_K, 4, number of LUT inputs.
- LUT_BITS, 2**LUT_K (16), truth-table width.
- CFG_BITS, LUT_BITS+1 (17), total configuration bits: truth table plus mode bit.

Ports:
- clk  input  1  single clock for all state; this is the global clk port.
- reset  input  1  synchronous, active-high reset.
- lut_in  input  LUT_K  LUT address inputs.
- lut_out  output  1  combinational LUT result, active_tt[lut_in]; feeds ff_D.
- ff_sel  output  1  active mode bit; 1 means the downstream BLE mux selects ff_Q, 0 selects lut_out.
- cfg_start  input  1  one-cycle pulse that begins a configuration load.
- cfg_abort  input  1  abandons a load in progress.
- cfg_data  input  1  serial configuration bit.
- cfg_valid  input  1  cfg_data is valid this cycle.
- cfg_ready  output  1  block accepts a bit this cycle.
- cfg_tail  output  1  registered bit shifted out of the shadow register, for chaining.
- cfg_done  output  1  active configuration was committed by a complete load.
- cfg_err  output  1  parity failure; exists only when CFG_PARITY_EN is defined, otherwise tied to 0.

Behaviour:
- States: IDLE, SHIFT, DONE (and ERR when the parity feature is compiled in).
- Reset (synchronous): state=IDLE; shadow=0; active_tt=0; ff_sel=0; bit count=0; cfg_ready=0; cfg_tail=0; cfg_done=0; cfg_err=0. The resulting lut_out is 0 for every lut_in.
- IDLE or DONE, with cfg_start=1: go to SHIFT next cycle; count=0; shadow is kept; cfg_done drops to 0 in the same transition.
- SHIFT:
  - cfg_ready=1.
  - A bit is accepted when cfg_valid & cfg_ready. On acceptance: shadow <= {cfg_data, shadow[CFG_BITS-1:1]}, cfg_tail <= shadow[0], count++.
  - Bit order: the first accepted bit ends up in shadow[0] = truth-table entry 0. The last accepted bit is the mode bit, shadow[CFG_BITS-1].
- Commit: the cycle after the acceptance that brings count to CFG_BITS, the block goes to DONE, active_tt <= shadow[LUT_BITS-1:0], ff_sel <= shadow[LUT_BITS], cfg_done=1 and cfg_ready=0.
- Atomic update: during SHIFT, lut_out and ff_sel keep using the old active configuration. They change only at commit.
- cfg_start while in SHIFT: ignored.
- cfg_abort while in SHIFT: go to IDLE next cycle; active_tt, ff_sel and cfg_done=0 are held; a partially filled shadow is kept. If cfg_abort and a bit acceptance occur in the same cycle, abort wins and the bit is discarded.
- cfg_abort in any other state: no effect.
- cfg_start asserted together with cfg_abort: abort wins when in SHIFT; start wins in IDLE or DONE.
- Reset mid-SHIFT: full reset, and the active configuration is cleared.
- Latency:
  - Minimum load time is CFG_BITS accepted cycles plus 1 commit cycle.
  - lut_out has zero latency from lut_in.

Optional Feature:
- CFG_PARITY_EN defined:
  - The load takes CFG_BITS+1 bits; the final bit is even parity over all CFG_BITS bits.
  - The parity bit is not stored in the shadow and is not shifted to cfg_tail.
  - On mismatch: go to ERR; no commit; cfg_err=1; active config unchanged; cfg_done=0.
  - ERR exits on cfg_start (to SHIFT, clearing cfg_err) or on reset.
- CFG_PARITY_EN not defined: the load is CFG_BITS bits, there is no ERR state, and cfg_err=0.

Decomposition:
- Shared package holds:
  - Constants LUT_K_DEF=4, LUT_BITS_DEF, CFG_BITS_DEF.
  - State enum cfg_state_t {IDLE, SHIFT, DONE, ERR}.
  - Function lut_eval(tt, addr).
- Sub-module cfg_shift_chain: shadow register, bit counter and tail logic, with shift_en, clear and full signals.
- The top level holds the FSM, the active registers and the LUT mux.

Test Plan:
- Reset, then sweep lut_in 0..15 -> lut_out=0 everywhere, ff_sel=0, cfg_done=0, cfg_ready=0.
- Load truth table 0x8000 (AND4) with mode bit 1, all 17 bits back-to-back -> cfg_done=1 exactly 1 cycle after the 17th bit; lut_out=1 only for lut_in=4'hF; ff_sel=1.
- Load with gaps: 0x6996 (XOR4) and mode 0, with cfg_valid toggling 1/0 -> commit only after 17 accepted bits; lut_out stays 0x8000 behaviour during the load and becomes parity behaviour after commit; cfg_tail reproduces the previous shadow bits in order.
- Abort after 9 bits (cfg_abort together with a valid bit) -> IDLE; config stays 0x8000; cfg_done=0; the 10th bit is not accepted; a subsequent full load commits correctly.
- Assert reset at bit 5 of a load -> next cycle everything is zeroed and lut_out=0; cfg_start in SHIFT mid-load is ignored (count continues).
- With CFG_PARITY_EN: correct parity -> commit; flipped parity bit -> cfg_err=1, config unchanged, no cfg_done; cfg_start then clears cfg_err.

Source files
------------

// File: rtl/ble4_lut4_cfg_pkg.sv
// ---------------------------------------------------------------------------
// ble4_lut4_cfg_pkg
// Shared definitions for the BLE LUT4 configuration slice:
//   - default LUT geometry (LUT_K_DEF, LUT_BITS_DEF, CFG_BITS_DEF)
//   - configuration FSM state type cfg_state_t
//   - lut_eval(): truth-table lookup used by the LUT mux
// ---------------------------------------------------------------------------
package ble4_lut4_cfg_pkg;

   localparam int LUT_K_DEF    = 4;
   localparam int LUT_BITS_DEF = 2 ** LUT_K_DEF;
   localparam int CFG_BITS_DEF = LUT_BITS_DEF + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2,
      ERR   = 2'd3
   } cfg_state_t;

   // Truth-table entry addr is the LUT output for that input combination.
   function automatic logic lut_eval(input logic [LUT_BITS_DEF-1:0] tt,
                                     input logic [LUT_K_DEF-1:0]    addr);
      return tt[addr];
   endfunction

endpackage

// File: rtl/ble4_lut4_cfg_shift_chain.sv
// ---------------------------------------------------------------------------
// ble4_lut4_cfg_shift_chain
// Shadow configuration register with stored-bit counter and chain tail.
// Bits enter at the MSB and move toward bit 0, so the first bit shifted in
// lands in shadow[0] once CFG_BITS bits have been stored.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   shift_en    : store data_in this cycle (ignored once full)
//   clear       : restart the bit count; shadow contents are kept
//   data_in     : serial configuration bit
//   shadow      : current shadow register contents
//   tail        : registered bit shifted out of shadow[0]
//   cnt         : number of bits stored since the last clear
//   full        : CFG_BITS bits stored
// ---------------------------------------------------------------------------
module ble4_lut4_cfg_shift_chain
   import ble4_lut4_cfg_pkg::*;
#(
   parameter int CFG_BITS = CFG_BITS_DEF
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              shift_en,
   input  logic                              clear,
   input  logic                              data_in,
   output logic [CFG_BITS-1:0]               shadow,
   output logic                              tail,
   output logic [$clog2(CFG_BITS+1)-1:0]     cnt,
   output logic                              full
);

   localparam int CNT_W = $clog2(CFG_BITS + 1);

   logic [CFG_BITS-1:0] shadow_q, shadow_d;
   logic                tail_q, tail_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   assign full   = (cnt_q == CNT_W'(CFG_BITS));
   assign shadow = shadow_q;
   assign tail   = tail_q;
   assign cnt    = cnt_q;

   always_comb begin
      shadow_d = shadow_q;
      tail_d   = tail_q;
      cnt_d    = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (shift_en && !full) begin
         shadow_d = {data_in, shadow_q[CFG_BITS-1:1]};
         tail_d   = shadow_q[0];
         cnt_d    = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q <= '0;
         tail_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         shadow_q <= shadow_d;
         tail_q   <= tail_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/ble4_lut4_cfg.sv
// ---------------------------------------------------------------------------
// ble4_lut4_cfg
// LUT4 stage of a BLE with serially loaded, atomically committed config.
// A load fills the shadow register over a valid/ready handshake; only a
// complete load updates the active truth table and mode bit, so lut_out and
// ff_sel never show a half-written configuration.
// Optional feature: define CFG_PARITY_EN to append an even-parity bit to
// every load; a mismatch parks the block in ERR with cfg_err set.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   lut_in      : LUT address inputs
//   lut_out     : combinational active_tt[lut_in], feeds ff_D
//   ff_sel      : active mode bit (1 = BLE mux selects ff_Q)
//   cfg_start   : begin a load (IDLE/DONE/ERR)
//   cfg_abort   : abandon a load in progress
//   cfg_data    : serial configuration bit, valid with cfg_valid
//   cfg_ready   : a bit is accepted this cycle when cfg_valid is high
//   cfg_tail    : bit shifted out of the shadow register, for chaining
//   cfg_done    : active configuration committed by a complete load
//   cfg_err     : parity failure (0 unless CFG_PARITY_EN)
// ---------------------------------------------------------------------------
module ble4_lut4_cfg
   import ble4_lut4_cfg_pkg::*;
#(
   parameter int LUT_K    = LUT_K_DEF,
   parameter int LUT_BITS = 2 ** LUT_K,
   parameter int CFG_BITS = LUT_BITS + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [LUT_K-1:0] lut_in,
   output logic             lut_out,
   output logic             ff_sel,
   input  logic             cfg_start,
   input  logic             cfg_abort,
   input  logic             cfg_data,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic             cfg_tail,
   output logic             cfg_done,
   output logic             cfg_err
);

   localparam int CNT_W = $clog2(CFG_BITS + 1);

   cfg_state_t          state_q, state_d;
   logic                ready_q, ready_d;
   logic                done_q, done_d;
   logic                pend_q, pend_d;   // last bit of the load taken, commit next cycle
   logic [LUT_BITS-1:0] active_tt_q, active_tt_d;
   logic                ff_sel_q, ff_sel_d;
`ifdef CFG_PARITY_EN
   logic                err_q, err_d;
   logic                bad_q, bad_d;     // parity mismatch seen on the final bit
`endif

   logic                shift_en, clear, full, tail, accept;
   logic [CFG_BITS-1:0] shadow;
   logic [CNT_W-1:0]    cnt;

   ble4_lut4_cfg_shift_chain #(.CFG_BITS(CFG_BITS)) u_chain (
      .clk      (clk),
      .reset    (reset),
      .shift_en (shift_en),
      .clear    (clear),
      .data_in  (cfg_data),
      .shadow   (shadow),
      .tail     (tail),
      .cnt      (cnt),
      .full     (full)
   );

   // ready_q is only ever high in SHIFT before the final bit
   assign accept = cfg_valid & ready_q;

   always_comb begin
      state_d     = state_q;
      ready_d     = ready_q;
      done_d      = done_q;
      pend_d      = pend_q;
      active_tt_d = active_tt_q;
      ff_sel_d    = ff_sel_q;
      shift_en    = 1'b0;
      clear       = 1'b0;
`ifdef CFG_PARITY_EN
      err_d       = err_q;
      bad_d       = bad_q;
`endif
      case (state_q)
         SHIFT: begin
            // abort beats both a pending commit and a bit offered this cycle
            if (cfg_abort) begin
               state_d = IDLE;
               ready_d = 1'b0;
               pend_d  = 1'b0;
            end else if (pend_q) begin
               pend_d = 1'b0;
`ifdef CFG_PARITY_EN
               if (bad_q) begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end else
`endif
               begin
                  state_d     = DONE;
                  active_tt_d = shadow[LUT_BITS-1:0];
                  ff_sel_d    = shadow[LUT_BITS];
                  done_d      = 1'b1;
               end
            end else if (accept) begin
`ifdef CFG_PARITY_EN
               if (!full) begin
                  shift_en = 1'b1;
               end else if (cnt == CNT_W'(CFG_BITS)) begin
                  // parity bit: checked against the stored bits, never stored
                  ready_d = 1'b0;
                  pend_d  = 1'b1;
                  bad_d   = (^shadow) ^ cfg_data;
               end
`else
               if (!full) begin
                  shift_en = 1'b1;
                  if (cnt == CNT_W'(CFG_BITS - 1)) begin
                     ready_d = 1'b0;
                     pend_d  = 1'b1;
                  end
               end
`endif
            end
         end
         default: begin
            // IDLE, DONE and ERR all restart a load on cfg_start; abort is a no-op here
            if (cfg_start) begin
               state_d = SHIFT;
               ready_d = 1'b1;
               done_d  = 1'b0;
               pend_d  = 1'b0;
               clear   = 1'b1;
`ifdef CFG_PARITY_EN
               err_d   = 1'b0;
               bad_d   = 1'b0;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ready_q     <= 1'b0;
         done_q      <= 1'b0;
         pend_q      <= 1'b0;
         active_tt_q <= '0;
         ff_sel_q    <= 1'b0;
`ifdef CFG_PARITY_EN
         err_q       <= 1'b0;
         bad_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         pend_q      <= pend_d;
         active_tt_q <= active_tt_d;
         ff_sel_q    <= ff_sel_d;
`ifdef CFG_PARITY_EN
         err_q       <= err_d;
         bad_q       <= bad_d;
`endif
      end
   end

   assign lut_out   = lut_eval(active_tt_q, lut_in);
   assign ff_sel    = ff_sel_q;
   assign cfg_ready = ready_q;
   assign cfg_done  = done_q;
   assign cfg_tail  = tail;
`ifdef CFG_PARITY_EN
   assign cfg_err   = err_q;
`else
   assign cfg_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ble4_lut4_cfg.sv
// ---------------------------------------------------------------------------
// tb_ble4_lut4_cfg
// Self-checking bench for ble4_lut4_cfg: directed loads from the test plan
// with literal expectations, then randomized traffic, all checked every
// cycle against a transaction-level model of the configuration behaviour.
// ---------------------------------------------------------------------------
module tb_ble4_lut4_cfg;

`ifdef CFG_PARITY_EN
   localparam bit PAR = 1'b1;
   localparam int NB  = 18;
`else
   localparam bit PAR = 1'b0;
   localparam int NB  = 17;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] lut_in = '0;
   logic       cfg_start = 1'b0, cfg_abort = 1'b0, cfg_data = 1'b0, cfg_valid = 1'b0;
   logic       lut_out, ff_sel, cfg_ready, cfg_tail, cfg_done, cfg_err;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   ble4_lut4_cfg dut (
      .clk       (clk),
      .reset     (reset),
      .lut_in    (lut_in),
      .lut_out   (lut_out),
      .ff_sel    (ff_sel),
      .cfg_start (cfg_start),
      .cfg_abort (cfg_abort),
      .cfg_data  (cfg_data),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_tail  (cfg_tail),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err)
   );

   task automatic chk(input string name, input logic got, input logic exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // hist holds every stored config bit in arrival order; the shadow is
   // simply its newest 17 entries, oldest of them at shadow[0].
   logic        hist[$];
   bit          m_load;
   int          m_cnt;
   logic [15:0] m_tt;
   logic        m_sel, m_done, m_err, m_tail, m_par;

   function automatic logic [16:0] shadow_val();
      logic [16:0] s;
      for (int i = 0; i < 17; i++) s[i] = hist[hist.size() - 17 + i];
      return s;
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < 17; i++) hist.push_back(1'b0);
      m_load = 0; m_cnt = 0; m_tt = '0; m_sel = 0;
      m_done = 0; m_err = 0; m_tail = 0; m_par = 0;
   endtask

   always @(posedge clk) begin
      logic [16:0] sh;
      if (reset) begin
         model_reset();
      end else if (m_load) begin
         if (cfg_abort) begin
            m_load = 0;
         end else if (m_cnt == NB) begin
            sh = shadow_val();
            if (PAR && ((^sh) != m_par)) m_err = 1;
            else begin
               m_tt = sh[15:0]; m_sel = sh[16]; m_done = 1;
            end
            m_load = 0;
         end else if (cfg_valid) begin
            if (m_cnt < 17) begin
               m_tail = hist[hist.size() - 17];
               hist.push_back(cfg_data);
               if (hist.size() > 64) void'(hist.pop_front());
            end else begin
               m_par = cfg_data;
            end
            m_cnt++;
         end
      end else if (cfg_start) begin
         m_load = 1; m_cnt = 0; m_done = 0; m_err = 0;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         chk("lut_out", lut_out, m_tt[lut_in]);
         chk("ff_sel", ff_sel, m_sel);
         chk("cfg_ready", cfg_ready, m_load && (m_cnt < NB));
         chk("cfg_done", cfg_done, m_done);
         chk("cfg_tail", cfg_tail, m_tail);
         chk("cfg_err", cfg_err, m_err);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic sweep_lit(input string name, input logic [15:0] tt);
      for (int i = 0; i < 16; i++) begin
         logic [3:0] a;
         a = 4'(i);
         lut_in = a;
         #1;
         chk(name, lut_out, tt[a]);
      end
   endtask

   // One load: cfg[0] first. abort_at / reset_at / start_at = bit index or -1.
   task automatic load(input logic [16:0] cfg, input bit gaps, input bit flip_par,
                       input int abort_at, input int reset_at, input int start_at);
      @(negedge clk); cfg_start = 1'b1;
      @(negedge clk); cfg_start = 1'b0;
      for (int i = 0; i < NB; i++) begin
         logic b;
         b = (i < 17) ? cfg[i] : ((^cfg) ^ flip_par);
         lut_in = 4'($urandom_range(0, 15));
         if (i == abort_at) begin
            cfg_valid = 1'b1; cfg_data = b; cfg_abort = 1'b1;
            @(negedge clk); cfg_valid = 1'b0; cfg_abort = 1'b0;
            return;
         end
         if (i == reset_at) begin
            reset = 1'b1;
            @(negedge clk); reset = 1'b0;
            return;
         end
         if (i == start_at) begin
            cfg_start = 1'b1;
            @(negedge clk); cfg_start = 1'b0;
         end
         cfg_valid = 1'b1; cfg_data = b;
         @(negedge clk); cfg_valid = 1'b0;
         if (gaps) @(negedge clk);
      end
   endtask

   initial begin
      // reset
      @(negedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sweep_lit("rst_lut", 16'h0000);
      chk("rst_ff_sel", ff_sel, 1'b0);
      chk("rst_done", cfg_done, 1'b0);
      chk("rst_ready", cfg_ready, 1'b0);

      // AND4, mode 1, back-to-back
      load({1'b1, 16'h8000}, 1'b0, 1'b0, -1, -1, -1);
      chk("and4_done_before_commit", cfg_done, 1'b0);
      chk("and4_ready_after_last", cfg_ready, 1'b0);
      @(negedge clk);
      chk("and4_done", cfg_done, 1'b1);
      chk("and4_ff_sel", ff_sel, 1'b1);
      sweep_lit("and4_lut", 16'h8000);

      // abort on bit 10 (together with a valid bit)
      load({1'b0, 16'h6996}, 1'b0, 1'b0, 9, -1, -1);
      chk("abort_ready", cfg_ready, 1'b0);
      chk("abort_done", cfg_done, 1'b0);
      @(negedge clk);
      chk("abort_idle_ready", cfg_ready, 1'b0);
      sweep_lit("abort_keep_lut", 16'h8000);
      chk("abort_keep_ff_sel", ff_sel, 1'b1);

      // XOR4, mode 0, with gaps between bits
      load({1'b0, 16'h6996}, 1'b1, 1'b0, -1, -1, -1);
      @(negedge clk);
      chk("xor4_done", cfg_done, 1'b1);
      chk("xor4_ff_sel", ff_sel, 1'b0);
      for (int i = 0; i < 16; i++) begin
         logic [3:0] a;
         a = 4'(i);
         lut_in = a;
         #1;
         chk("xor4_lut", lut_out, ^a);
      end

      // cfg_start mid-load is ignored
      load({1'b1, 16'hA5C3}, 1'b0, 1'b0, -1, -1, 6);
      @(negedge clk);
      chk("midstart_done", cfg_done, 1'b1);
      sweep_lit("midstart_lut", 16'hA5C3);

      // reset at bit 5
      load({1'b1, 16'hFFFF}, 1'b0, 1'b0, -1, 5, -1);
      sweep_lit("midreset_lut", 16'h0000);
      chk("midreset_ff_sel", ff_sel, 1'b0);
      chk("midreset_tail", cfg_tail, 1'b0);
      chk("midreset_ready", cfg_ready, 1'b0);

`ifdef CFG_PARITY_EN
      load({1'b1, 16'h1234}, 1'b0, 1'b0, -1, -1, -1);
      @(negedge clk);
      chk("par_ok_done", cfg_done, 1'b1);
      chk("par_ok_err", cfg_err, 1'b0);
      load({1'b0, 16'h00FF}, 1'b0, 1'b1, -1, -1, -1);
      @(negedge clk);
      chk("par_bad_err", cfg_err, 1'b1);
      chk("par_bad_done", cfg_done, 1'b0);
      sweep_lit("par_bad_keep_lut", 16'h1234);
      cfg_start = 1'b1;
      @(negedge clk); cfg_start = 1'b0;
      chk("par_restart_err", cfg_err, 1'b0);
      cfg_abort = 1'b1;
      @(negedge clk); cfg_abort = 1'b0;
`endif

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         cfg_valid = ($urandom_range(0, 9) < 6);
         cfg_data  = 1'($urandom_range(0, 1));
         cfg_start = ($urandom_range(0, 19) == 0);
         cfg_abort = ($urandom_range(0, 59) == 0);
         reset     = ($urandom_range(0, 399) == 0);
         lut_in    = 4'($urandom_range(0, 15));
         @(negedge clk);
      end
      cfg_valid = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; reset = 1'b0;
      @(negedge clk);
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
